// File: rtl/delay_scheduler.sv
// ---------------------------------------------------------------------------
// delay_scheduler
//
// Shares one 32-bit Delay unit between G_NREQ requesters. One request is
// accepted at a time with round-robin priority. The scheduler drives the
// request into the delay unit and waits for the delayed word. It then returns
// that word to the requester that issued it. A watchdog abandons the
// transaction if the delay unit never answers.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous, active-high reset
//   req_valid / req_ready  per-requester request handshake (ready is one-hot)
//   req_data               requester i occupies bits [32i+31:32i]
//   resp_valid / resp_ready per-requester response handshake (valid one-hot)
//   resp_data              shared response word, valid while any resp_valid
//   dly_data_in(_valid)    drive the shared Delay instance
//   dly_delayed_data(_valid) result coming back from the Delay instance
//   busy                   high whenever the FSM is not idle
//   owner                  current or most recently granted requester
//   timeout_err            one-cycle pulse when a transaction is aborted
// ---------------------------------------------------------------------------
module delay_scheduler #(
    parameter int G_NREQ    = 4,
    parameter int G_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [G_NREQ-1:0]         req_valid,
    output logic [G_NREQ-1:0]         req_ready,
    input  logic [32*G_NREQ-1:0]      req_data,
    output logic [G_NREQ-1:0]         resp_valid,
    input  logic [G_NREQ-1:0]         resp_ready,
    output logic [31:0]               resp_data,
    output logic [31:0]               dly_data_in,
    output logic                      dly_data_in_valid,
    input  logic [31:0]               dly_delayed_data,
    input  logic                      dly_delayed_data_valid,
    output logic                      busy,
    output logic [$clog2(G_NREQ)-1:0] owner,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(G_NREQ);
    localparam int CNT_W = $clog2(G_TIMEOUT + 1);
    localparam logic [G_NREQ-1:0] ONE_HOT_LSB = {{(G_NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [31:0]         data_q_r;
    logic [31:0]         resp_q_r;
    logic [IDX_W-1:0]    owner_r;
    logic [IDX_W-1:0]    last_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                timeout_err_r;

    logic                grant_found_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic [31:0]         grant_data_s;
    logic                accept_s;
    logic                capture_s;
    logic                timeout_s;
    logic                release_s;
    logic [G_NREQ-1:0]   req_ready_s;
    logic [G_NREQ-1:0]   resp_valid_s;
    logic                dly_data_in_valid_s;

    // Round-robin search: first valid requester starting just after last_r.
    always_comb begin
        logic [31:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_v        = 32'd0;
        for (int k = 1; k <= G_NREQ; k++) begin
            cand_v = (32'(last_r) + 32'(k)) % 32'(G_NREQ);
            if (!grant_found_s && req_valid[cand_v[IDX_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v[IDX_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign grant_data_s = req_data[{grant_idx_s, 5'b00000} +: 32];

    // Next-state and per-state strobes of the transaction FSM.
    always_comb begin
        state_next_s        = state_r;
        accept_s            = 1'b0;
        capture_s           = 1'b0;
        timeout_s           = 1'b0;
        release_s           = 1'b0;
        req_ready_s         = '0;
        resp_valid_s        = '0;
        dly_data_in_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Reset also masks the combinational grant so every output reads 0.
                if (grant_found_s && !rst) begin
                    accept_s     = 1'b1;
                    req_ready_s  = ONE_HOT_LSB << grant_idx_s;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                dly_data_in_valid_s = 1'b1;
                state_next_s        = ST_WAIT;
            end
            ST_WAIT: begin
                // A genuine answer wins over an expiring watchdog in the same cycle.
                if (dly_delayed_data_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else if (wait_cnt_r == CNT_W'(G_TIMEOUT - 1)) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                resp_valid_s = ONE_HOT_LSB << owner_r;
                if (resp_ready[owner_r]) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: request/response words, ownership, priority pointer, watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q_r      <= 32'd0;
            resp_q_r      <= 32'd0;
            owner_r       <= '0;
            last_r        <= IDX_W'(G_NREQ - 1);
            wait_cnt_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                data_q_r <= grant_data_s;
                owner_r  <= grant_idx_s;
            end
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
            if (capture_s) begin
                resp_q_r <= dly_delayed_data;
            end
            if (timeout_s || release_s) begin
                last_r <= owner_r;
            end
            timeout_err_r <= timeout_s;
        end
    end

    assign req_ready         = req_ready_s;
    assign resp_valid        = resp_valid_s;
    assign resp_data         = resp_q_r;
    assign dly_data_in       = data_q_r;
    assign dly_data_in_valid = dly_data_in_valid_s;
    assign busy              = (state_r != ST_IDLE);
    assign owner             = owner_r;
    assign timeout_err       = timeout_err_r;

endmodule
